// File: rtl/pipe_mux_reg.sv
// -----------------------------------------------------------------------------
// pipe_mux_reg
//   NUM_IN-way WIDTH-bit operand selector followed by a 2-entry skid buffer
//   with valid/ready flow control and a synchronous flush. The output side
//   (out_data, out_valid) and the input-side in_ready all come straight from
//   registers, so stalls and flushes never create a combinational ready path.
//
// Parameters:
//   WIDTH   data width of each channel and of out_data
//   NUM_IN  number of input channels (>= 2)
//   SEL_W   select width, derived from NUM_IN (not overridable)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    packed channels, channel k = in_data[k*WIDTH +: WIDTH]
//   sel        channel select, sampled together with in_valid
//   in_valid   upstream beat valid
//   in_ready   a beat can be accepted this cycle
//   out_data   data of the head beat
//   out_valid  head beat valid
//   out_ready  downstream accepts the head beat
//   flush      discard all held beats at the next edge
//   sel_err    (only with PIPE_MUX_SEL_ERR_EN) head beat was selected with an
//              out-of-range sel; meaningful only while out_valid=1
//
// Optional feature macro: PIPE_MUX_SEL_ERR_EN
// -----------------------------------------------------------------------------
module pipe_mux_reg #(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush
`ifdef PIPE_MUX_SEL_ERR_EN
   ,output logic                    sel_err
`endif
);

    // Encoding is {skid_valid, main_valid}, so the state bits themselves are
    // the registered in_ready / out_valid sources.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_data, skid_data;
    logic [WIDTH-1:0] sel_data;
    logic             accept, deliver;
    logic             load_main, load_skid, main_from_skid;

    // Channel select; an out-of-range sel matches no channel and yields zero.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    assign out_data  = main_data;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (deliver && accept) begin
                    load_main = 1'b1;
                end else if (deliver) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path exists.
                if (deliver) begin
                    state_nxt      = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins over accept and deliver; data loads are left alone since
        // the cleared valids make the data registers don't-care.
        if (flush) state_nxt = EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // NOTE: the data registers are reset too, because out_data must read zero
    // straight out of reset rather than whatever the flops powered up with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main)           main_data <= sel_data;
            else if (main_from_skid) main_data <= skid_data;
            if (load_skid)           skid_data <= sel_data;
        end
    end

`ifdef PIPE_MUX_SEL_ERR_EN
    // Per-beat out-of-range flag travels through main/skid with its data.
    // For a power-of-two NUM_IN the compare is constant false.
    logic sel_oor;
    logic main_err, skid_err;

    assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
    assign sel_err = main_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_err <= 1'b0;
            skid_err <= 1'b0;
        end else if (flush) begin
            main_err <= 1'b0;
            skid_err <= 1'b0;
        end else begin
            if (load_main)           main_err <= sel_oor;
            else if (main_from_skid) main_err <= skid_err;
            if (load_skid)           skid_err <= sel_oor;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_mux_reg
//   Drives two instances (NUM_IN=4 and NUM_IN=3, WIDTH=32) with one shared
//   control stream. A queue model of the in-order 2-deep buffer predicts
//   in_ready, out_valid, out_data (and sel_err when PIPE_MUX_SEL_ERR_EN is
//   defined) and is compared on every falling edge; directed scenarios add
//   literal expectations sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_mux_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data4;
    logic [95:0]  in_data3;
    logic [1:0]   sel;
    logic         in_valid, out_ready, flush;
    logic         in_ready4, out_valid4, in_ready3, out_valid3;
    logic [31:0]  out_data4, out_data3;
`ifdef PIPE_MUX_SEL_ERR_EN
    logic         sel_err4, sel_err3;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] vals [4];

    always #5 clk = ~clk;

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .flush(flush)
`ifdef PIPE_MUX_SEL_ERR_EN
       ,.sel_err(sel_err4)
`endif
    );

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready), .flush(flush)
`ifdef PIPE_MUX_SEL_ERR_EN
       ,.sel_err(sel_err3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_chan();
        in_data4 = {vals[3], vals[2], vals[1], vals[0]};
        in_data3 = {vals[2], vals[1], vals[0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model: FIFO of at most two beats ----------------
    typedef struct {
        logic [31:0] d;
        bit          e;
    } beat_t;

    beat_t q4[$];
    beat_t q3[$];
    bit    m_acc, m_dlv;

    function automatic logic [31:0] chan(input int n, input int s);
        return (s < n) ? vals[s] : 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q4.delete();
            q3.delete();
        end else begin
            m_acc = in_valid && (q4.size() < 2);
            m_dlv = out_ready && (q4.size() > 0);
            if (flush) begin
                q4.delete();
                q3.delete();
            end else begin
                if (m_dlv) begin
                    void'(q4.pop_front());
                    void'(q3.pop_front());
                end
                if (m_acc) begin
                    q4.push_back('{chan(4, int'(sel)), int'(sel) >= 4});
                    q3.push_back('{chan(3, int'(sel)), int'(sel) >= 3});
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("in_ready4",  {31'b0, in_ready4},  {31'b0, q4.size() < 2});
        check("out_valid4", {31'b0, out_valid4}, {31'b0, q4.size() > 0});
        check("in_ready3",  {31'b0, in_ready3},  {31'b0, q3.size() < 2});
        check("out_valid3", {31'b0, out_valid3}, {31'b0, q3.size() > 0});
        if (q4.size() > 0) check("out_data4", out_data4, q4[0].d);
        if (q3.size() > 0) check("out_data3", out_data3, q3[0].d);
`ifdef PIPE_MUX_SEL_ERR_EN
        if (q4.size() > 0) check("sel_err4", {31'b0, sel_err4}, {31'b0, q4[0].e});
        if (q3.size() > 0) check("sel_err3", {31'b0, sel_err3}, {31'b0, q3[0].e});
`endif
    end

    // ---------------- directed + looped stimulus ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; sel = 2'd0;
        vals[0] = 32'hA0; vals[1] = 32'hB1; vals[2] = 32'hC2; vals[3] = 32'hD3;
        set_chan();
        #23 rst_n = 1'b1;
        tick();
        check("rst out_valid", {31'b0, out_valid4}, 32'd0);
        check("rst out_data",  out_data4, 32'h0);
        check("rst in_ready",  {31'b0, in_ready4}, 32'd1);
        check("rst out_data3", out_data3, 32'h0);

        // Streaming, 1-cycle latency, in_ready stays high.
        in_valid = 1'b1; sel = 2'd2; tick();
        check("stream C2", out_data4, 32'hC2);
        check("stream rdy", {31'b0, in_ready4}, 32'd1);
        sel = 2'd0; tick();
        check("stream A0", out_data4, 32'hA0);
        sel = 2'd3; tick();
        check("stream D3", out_data4, 32'hD3);
        check("oor data3", out_data3, 32'h0);
        check("oor valid3", {31'b0, out_valid3}, 32'd1);
`ifdef PIPE_MUX_SEL_ERR_EN
        check("oor err3", {31'b0, sel_err3}, 32'd1);
        check("inrange err4", {31'b0, sel_err4}, 32'd0);
`endif
        in_valid = 1'b0; tick();
        check("drain valid", {31'b0, out_valid4}, 32'd0);

        // Backpressure into the skid entry.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; tick();
        check("bp B1", out_data4, 32'hB1);
`ifdef PIPE_MUX_SEL_ERR_EN
        check("next err3", {31'b0, sel_err3}, 32'd0);
`endif
        sel = 2'd3; tick();
        check("bp full rdy", {31'b0, in_ready4}, 32'd0);
        check("bp hold B1", out_data4, 32'hB1);
        in_valid = 1'b0; tick();
        check("bp hold2 B1", out_data4, 32'hB1);
        out_ready = 1'b1; tick();
        check("bp D3", out_data4, 32'hD3);
        check("bp rdy back", {31'b0, in_ready4}, 32'd1);
        tick();
        check("bp empty", {31'b0, out_valid4}, 32'd0);

        // Flush from FULL with a pending in_valid.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; tick();
        sel = 2'd2; tick();
        check("fl full", {31'b0, in_ready4}, 32'd0);
        flush = 1'b1; sel = 2'd0; tick();
        check("fl valid", {31'b0, out_valid4}, 32'd0);
        check("fl rdy", {31'b0, in_ready4}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        check("fl no A0", {31'b0, out_valid4}, 32'd0);

        // Flush from ONE: the beat accepted in the flush cycle is dropped.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; tick();
        flush = 1'b1; sel = 2'd0; tick();
        check("fl1 valid", {31'b0, out_valid4}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        check("fl1 no beat", {31'b0, out_valid4}, 32'd0);

        // Asynchronous reset while FULL.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; tick();
        sel = 2'd2; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", {31'b0, out_valid4}, 32'd0);
        check("arst rdy",   {31'b0, in_ready4},  32'd1);
        check("arst data",  out_data4, 32'h0);
        tick();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst no stale", {31'b0, out_valid4}, 32'd0);

        // Mixed traffic checked by the model.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) vals[k] = $urandom;
            set_chan();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            sel       = 2'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mux_reg.md
Name: pipe_mux_reg

Overview:
Parametrised N-way operand selector with a registered, flow-controlled output stage. It is the successor of the processor's combinational 2:1 32-bit mux.
- Selects one of NUM_IN WIDTH-bit channels per beat.
- Carries the beat through a 2-entry skid buffer with valid/ready handshakes.
- Supports a synchronous pipeline flush.
- Sits between the forwarding/operand-select logic and the execute stage, so stalls and flushes propagate without combinational ready paths.

Parameters:
WIDTH, 32, data width of each channel and of out_data
NUM_IN, 4, number of input channels (>=2)
SEL_W, $clog2(NUM_IN), select width; derived localparam, not overridable

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH]
sel  input  SEL_W  channel select, sampled with in_valid
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat this cycle (registered)
out_data  output  WIDTH  selected data of head beat
out_valid  output  1  head beat valid
out_ready  input  1  downstream accepts head beat
flush  input  1  synchronous discard of all held beats

Behaviour:
- Reset (rst_n=0, asynchronous):
  - main_valid=0, skid_valid=0, main_data=0, skid_data=0.
  - Outputs: out_valid=0, out_data=0, in_ready=1.
- Select: sel_data = channel[sel] when sel < NUM_IN, else all-zero. Pure combinational, computed on the input side.
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- in_ready = ~skid_valid, driven from a register. There is no combinational path from out_ready to in_ready.
- out_data = main_data and out_valid = main_valid, both driven directly from registers.
- Latency: an accepted beat is visible on out_data/out_valid the next cycle when the buffer was EMPTY or delivering.
- State (main_valid, skid_valid):
  - EMPTY (0,0):
    - accept -> ONE; main loads sel_data.
  - ONE (1,0):
    - deliver && !accept -> EMPTY.
    - deliver && accept -> ONE; main loads new sel_data.
    - !deliver && accept -> FULL; skid loads sel_data, main holds.
    - !deliver && !accept -> ONE, hold.
  - FULL (1,1): in_ready=0, so no accept.
    - deliver -> ONE; main loads skid_data, skid clears.
    - !deliver -> hold.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Flush:
  - Same cycle: both valids clear at the next edge; an accept in the flush cycle is discarded; in_ready=1 the following cycle.
  - Data registers are not required to clear on flush.
  - Priority: flush beats accept and deliver. A beat delivered in the flush cycle still counts as delivered downstream.
- out_data must stay stable while out_valid=1 && out_ready=0.
- Reset mid-operation: all held beats are lost immediately. No output glitches other than the asynchronous clear.
- sel changes while in_valid=0 have no effect.

Optional Feature:
Macro PIPE_MUX_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit).
  - Each beat carries a flag set when sel >= NUM_IN at acceptance. The flag moves through main/skid alongside the data.
  - sel_err equals the flag of the head beat, valid only with out_valid.
  - Reset and flush clear it.
- Undefined:
  - No sel_err port and no flag storage.
  - Out-of-range select silently yields zero data.
- When NUM_IN is a power of two, sel_err is constantly 0.

Test Plan:
- Reset release with NUM_IN=4, WIDTH=32, out_ready=1 -> out_valid=0, out_data=0, in_ready=1 in the first cycle after rst_n rises.
- Channels {0xA0,0xB1,0xC2,0xD3}; stream sel=2,0,3 with in_valid=1, out_ready=1 -> out_data 0xC2,0xA0,0xD3 on consecutive cycles, 1-cycle latency, in_ready held 1.
- out_ready=0 while accepting beats sel=1 then sel=3 -> second beat goes to skid, in_ready=0 next cycle, out_data holds 0xB1. Raise out_ready -> 0xB1 then 0xD3 delivered in order, in_ready returns to 1.
- FULL state, assert flush with in_valid=1 sel=0 -> next cycle out_valid=0, in_ready=1, the 0xA0 beat never appears.
- NUM_IN=3, sel=3 with PIPE_MUX_SEL_ERR_EN defined -> out_data=0, sel_err=1 on that beat only; next beat sel=1 -> sel_err=0.
- Drop rst_n low while FULL, asynchronous to clk -> out_valid=0 and in_ready=1 immediately; no stale beat after release.
